flash_loader: RTL and testbench

Copies a contiguous block of words out of the serial flash into on-chip RAM after reset or on request. Sits directly upstream of `flash_serial`: it drives that block's enable/read/address inputs and consumes its `out_data` / `out_word_finished` stream, turning each finished word into a single-cycle RAM write. Typical use is boot-time loading of program or table memory.

---
 rtl/flash_pkg.sv | 20 ++
 rtl/flash_loader_edge_detect.sv | 26 ++
 rtl/flash_loader.sv | 176 +++++++++++++++++
 tb/tb_flash_loader.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// flash_pkg: loader state encoding, flash command codes shared with flash_serial,
// and default timing parameters for flash_loader.
package flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_COPY    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } t_loader_state;

    localparam logic [7:0] FLASH_CMD_READ      = 8'h03;
    localparam logic [7:0] FLASH_CMD_FAST_READ = 8'h0B;

    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;
    localparam int DEFAULT_RELEASE_CYCLES = 16;

endpackage

// File: rtl/flash_loader_edge_detect.sv
// edge_detect: rising-edge detector built on a registered copy of the input
// (previous value resets to 0).
`default_nettype none

module edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/flash_loader.sv
// flash_loader: copies in_len words from serial flash into RAM, one write per word.
// Optional FLASH_LOADER_CHECKSUM_EN adds a running modulo-2^WORD_BITS word checksum.
`default_nettype none

module flash_loader
    import flash_pkg::*;
#(
    parameter int WORD_BITS      = 8,
    parameter int ADDRESS_WORDS  = 2,
    parameter int MEM_ADDR_BITS  = 10,
    parameter int LEN_BITS       = 16,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES
) (
    input  logic                               in_clk,
    input  logic                               in_rst,
    input  logic                               in_start,
    input  logic [WORD_BITS*ADDRESS_WORDS-1:0] in_flash_addr,
    input  logic [MEM_ADDR_BITS-1:0]           in_mem_addr,
    input  logic [LEN_BITS-1:0]                in_len,
    output logic                               out_busy,
    output logic                               out_done,
    output logic                               out_error,
    output logic                               out_flash_enable,
    output logic                               out_flash_read,
    output logic [WORD_BITS*ADDRESS_WORDS-1:0] out_flash_addr,
    input  logic [WORD_BITS-1:0]               in_flash_data,
    input  logic                               in_flash_word_finished,
    output logic                               out_mem_write,
    output logic [MEM_ADDR_BITS-1:0]           out_mem_addr,
    output logic [WORD_BITS-1:0]               out_mem_data,
    output logic [WORD_BITS-1:0]               out_checksum
);

    localparam int FA = WORD_BITS * ADDRESS_WORDS;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int RW = $clog2(RELEASE_CYCLES) + 1;

    t_loader_state            state_q;
    logic [FA-1:0]            flash_addr_q;
    logic [MEM_ADDR_BITS-1:0] ptr_q;
    logic [MEM_ADDR_BITS-1:0] wr_addr_q;
    logic [WORD_BITS-1:0]     wr_data_q;
    logic [LEN_BITS-1:0]      len_q;
    logic [LEN_BITS-1:0]      cnt_q;
    logic [TW-1:0]            tmo_q;
    logic [RW-1:0]            rel_q;
    logic                     timed_out_q;
    logic                     enable_q;
    logic                     write_q;
    logic                     done_q;
    logic                     error_q;
    logic                     w_word_evt;

    edge_detect u_edge_detect (
        .clk_i  (in_clk),
        .rst_i  (in_rst),
        .sig_i  (in_flash_word_finished),
        .rise_o (w_word_evt)
    );

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q      <= ST_IDLE;
            flash_addr_q <= '0;
            ptr_q        <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            rel_q        <= '0;
            timed_out_q  <= 1'b0;
            enable_q     <= 1'b0;
            write_q      <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            write_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_start) begin
                        if (in_len != '0) begin
                            flash_addr_q <= in_flash_addr;
                            ptr_q        <= in_mem_addr;
                            len_q        <= in_len;
                            state_q      <= ST_START;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_START: begin
                    enable_q    <= 1'b1;
                    cnt_q       <= '0;
                    tmo_q       <= '0;
                    timed_out_q <= 1'b0;
                    state_q     <= ST_COPY;
                end
                ST_COPY: begin
                    // Length test comes first so enable drops the cycle after the last write.
                    if (cnt_q == len_q) begin
                        enable_q <= 1'b0;
                        rel_q    <= '0;
                        state_q  <= ST_RELEASE;
                    end else if (w_word_evt) begin
                        write_q   <= 1'b1;
                        wr_addr_q <= ptr_q;
                        wr_data_q <= in_flash_data;
                        ptr_q     <= ptr_q + MEM_ADDR_BITS'(1);
                        cnt_q     <= cnt_q + LEN_BITS'(1);
                        tmo_q     <= '0;
                    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        enable_q    <= 1'b0;
                        rel_q       <= '0;
                        timed_out_q <= 1'b1;
                        state_q     <= ST_RELEASE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (rel_q == RW'(RELEASE_CYCLES - 1)) begin
                        state_q <= timed_out_q ? ST_ERROR : ST_DONE;
                    end else begin
                        rel_q <= rel_q + RW'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                ST_ERROR: begin
                    error_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FLASH_LOADER_CHECKSUM_EN
    logic [WORD_BITS-1:0] sum_q;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            sum_q <= '0;
        end else if (state_q == ST_START) begin
            sum_q <= '0;
        end else if (write_q) begin
            sum_q <= sum_q + wr_data_q;
        end
    end

    assign out_checksum = sum_q;
`else
    assign out_checksum = '0;
`endif

    assign out_busy         = (state_q != ST_IDLE);
    assign out_done         = done_q;
    assign out_error        = error_q;
    assign out_flash_enable = enable_q;
    assign out_flash_read   = 1'b1;
    assign out_flash_addr   = flash_addr_q;
    assign out_mem_write    = write_q;
    assign out_mem_addr     = wr_addr_q;
    assign out_mem_data     = wr_data_q;

endmodule

`default_nettype wire

// File: tb/tb_flash_loader.sv
// tb_flash_loader: randomized self-checking bench for flash_loader with a
// behavioural flash source and an expected-write model.
`default_nettype none

module tb_flash_loader;

    localparam int TO = 4096;
    localparam int RC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_start;
    logic [15:0] in_flash_addr;
    logic [9:0]  in_mem_addr;
    logic [15:0] in_len;
    logic [7:0]  flash_data;
    logic        wf;
    logic        out_busy, out_done, out_error, out_flash_enable, out_flash_read;
    logic [15:0] out_flash_addr;
    logic        out_mem_write;
    logic [9:0]  out_mem_addr;
    logic [7:0]  out_mem_data;
    logic [7:0]  out_checksum;

    flash_loader #(
        .WORD_BITS      (8),
        .ADDRESS_WORDS  (2),
        .MEM_ADDR_BITS  (10),
        .LEN_BITS       (16),
        .TIMEOUT_CYCLES (TO),
        .RELEASE_CYCLES (RC)
    ) dut (
        .in_clk                 (clk),
        .in_rst                 (rst),
        .in_start               (in_start),
        .in_flash_addr          (in_flash_addr),
        .in_mem_addr            (in_mem_addr),
        .in_len                 (in_len),
        .out_busy               (out_busy),
        .out_done               (out_done),
        .out_error              (out_error),
        .out_flash_enable       (out_flash_enable),
        .out_flash_read         (out_flash_read),
        .out_flash_addr         (out_flash_addr),
        .in_flash_data          (flash_data),
        .in_flash_word_finished (wf),
        .out_mem_write          (out_mem_write),
        .out_mem_addr           (out_mem_addr),
        .out_mem_data           (out_mem_data),
        .out_checksum           (out_checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write/pulse monitor, sampled on the falling edge
    logic [9:0] obs_a[$];
    logic [7:0] obs_d[$];
    int n_done = 0, n_error = 0;
    int done_cyc = 0, err_cyc = 0, last_wr_cyc = 0, en_fall_cyc = 0;
    bit en_seen = 0, en_prev = 0;

    always @(negedge clk) begin
        if (out_mem_write) begin
            obs_a.push_back(out_mem_addr);
            obs_d.push_back(out_mem_data);
            last_wr_cyc = cyc;
        end
        if (out_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (out_error) begin
            n_error++;
            err_cyc = cyc;
        end
        if (out_flash_enable) en_seen = 1'b1;
        if (en_prev && !out_flash_enable) en_fall_cyc = cyc;
        en_prev = out_flash_enable;
    end

    // Flash content as seen by the loader
    function automatic logic [7:0] fdata(input logic [15:0] a);
        case (a)
            16'h0100: return 8'h11;
            16'h0101: return 8'h22;
            16'h0102: return 8'h33;
            16'h0103: return 8'h44;
            default:  return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [7:0] exp_checksum(input logic [15:0] fa, input int n);
        logic [7:0] s;
        s = 8'h00;
`ifdef FLASH_LOADER_CHECKSUM_EN
        for (int i = 0; i < n; i++) s = s + fdata(fa + 16'(i));
`endif
        return s;
    endfunction

    task automatic clear_mon();
        obs_a.delete();
        obs_d.delete();
        n_done  = 0;
        n_error = 0;
        en_seen = 1'b0;
    endtask

    task automatic start_xfer(input logic [15:0] fa, input logic [9:0] ma,
                              input logic [15:0] ln, output int scyc);
        @(negedge clk);
        in_flash_addr = fa;
        in_mem_addr   = ma;
        in_len        = ln;
        in_start      = 1'b1;
        scyc          = cyc;
        @(negedge clk);
        in_start      = 1'b0;
        in_flash_addr = 16'($urandom);
        in_mem_addr   = 10'($urandom);
        in_len        = 16'($urandom);
    endtask

    task automatic send_word(input logic [7:0] d, input int hold, output logic w1,
                             output logic [9:0] a1, output logic [7:0] d1, output logic w2);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        flash_data = d;
        wf = 1'b1;
        @(negedge clk);
        w1 = out_mem_write;
        a1 = out_mem_addr;
        d1 = out_mem_data;
        w2 = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            w2 = w2 | out_mem_write;
        end
        wf = 1'b0;
        flash_data = 8'($urandom);
        @(negedge clk);
        w2 = w2 | out_mem_write;
    endtask

    task automatic serve_n(input int n, input int first);
        logic w1, w2;
        logic [9:0] a1;
        logic [7:0] d1;
        for (int i = 0; i < n; i++)
            send_word(fdata(out_flash_addr + 16'(first + i)), $urandom_range(0, 2), w1, a1, d1, w2);
    endtask

    task automatic wait_enable(output bit to);
        to = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_flash_enable) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Returns one cycle after the done/error pulse so monitor counters are settled
    task automatic wait_end(input int bound, output bit to);
        to = 1'b1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (out_done || out_error) begin
                to = 1'b0;
                @(negedge clk);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_busy, out_done, out_error, out_flash_enable, out_flash_read, out_flash_addr,
             out_mem_write, out_mem_addr, out_mem_data, out_checksum} !==
            {4'b0000, 1'b1, 16'h0000, 1'b0, 10'h000, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b en=%b rd=%b fa=%h wr=%b ma=%h md=%h cs=%h required all 0 except rd=1",
                     out_busy, out_done, out_error, out_flash_enable, out_flash_read, out_flash_addr,
                     out_mem_write, out_mem_addr, out_mem_data, out_checksum);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b required 0", out_busy);
        end
    endtask

    task automatic test_basic();
        int scyc;
        bit to;
        logic w1, w2;
        logic [9:0] a1;
        logic [7:0] d1;
        clear_mon();
        start_xfer(16'h0100, 10'h010, 16'd4, scyc);
        checks++;
        if (out_flash_enable !== 1'b0 || out_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_latency_early: en=%b busy=%b required en=0 busy=1", out_flash_enable, out_busy);
        end
        @(negedge clk);
        checks++;
        if (out_flash_enable !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: en=%b required 1 two cycles after start", out_flash_enable);
        end
        for (int i = 0; i < 4; i++) begin
            send_word(fdata(out_flash_addr + 16'(i)), i % 3, w1, a1, d1, w2);
            checks++;
            if ({w1, a1, d1} !== {1'b1, 10'h010 + 10'(i), 8'h11 * 8'(i + 1)}) begin
                errors++;
                $display("FAIL word_latency[%0d]: wr=%b addr=%h data=%h required wr=1 addr=%h data=%h",
                         i, w1, a1, d1, 10'h010 + 10'(i), 8'h11 * 8'(i + 1));
            end
            checks++;
            if (w2 !== 1'b0) begin
                errors++;
                $display("FAIL write_one_cycle[%0d]: extra write strobe=%b required 0", i, w2);
            end
        end
        wait_end(100, to);
        checks++;
        if (to || n_done !== 1 || n_error !== 0 || obs_a.size() !== 4) begin
            errors++;
            $display("FAIL basic_done: timeout=%0d done=%0d error=%0d writes=%0d required 0/1/0/4",
                     to, n_done, n_error, obs_a.size());
        end
        checks++;
        if (en_fall_cyc - last_wr_cyc !== 1 || done_cyc - en_fall_cyc !== RC + 1) begin
            errors++;
            $display("FAIL release_timing: en_low-wr=%0d done-en_low=%0d required 1 and %0d",
                     en_fall_cyc - last_wr_cyc, done_cyc - en_fall_cyc, RC + 1);
        end
        checks++;
        if (out_checksum !== exp_checksum(16'h0100, 4)) begin
            errors++;
            $display("FAIL basic_checksum: got %h required %h", out_checksum, exp_checksum(16'h0100, 4));
        end
    endtask

    task automatic test_zero_len();
        int scyc;
        bit to;
        clear_mon();
        start_xfer(16'($urandom), 10'($urandom), 16'd0, scyc);
        wait_end(20, to);
        checks++;
        if (to || done_cyc - scyc !== 2 || n_done !== 1) begin
            errors++;
            $display("FAIL zero_len_done: timeout=%0d latency=%0d dones=%0d required 0/2/1",
                     to, done_cyc - scyc, n_done);
        end
        checks++;
        if (en_seen !== 1'b0 || obs_a.size() !== 0 || n_error !== 0) begin
            errors++;
            $display("FAIL zero_len_quiet: enable_seen=%b writes=%0d errors=%0d required 0/0/0",
                     en_seen, obs_a.size(), n_error);
        end
    endtask

    task automatic test_timeout();
        int scyc;
        bit to;
        logic [15:0] fa;
        logic [9:0] ma;
        fa = 16'($urandom);
        ma = 10'($urandom);
        clear_mon();
        start_xfer(fa, ma, 16'd3, scyc);
        wait_enable(to);
        serve_n(2, 0);
        wait_end(TO + RC + 50, to);
        checks++;
        if (to || n_error !== 1 || n_done !== 0) begin
            errors++;
            $display("FAIL timeout_error: timeout=%0d errors=%0d dones=%0d required 0/1/0", to, n_error, n_done);
        end
        checks++;
        if (err_cyc - last_wr_cyc !== TO + RC + 1) begin
            errors++;
            $display("FAIL timeout_latency: got %0d required %0d", err_cyc - last_wr_cyc, TO + RC + 1);
        end
        checks++;
        if (obs_a.size() !== 2) begin
            errors++;
            $display("FAIL timeout_writes: got %0d required 2", obs_a.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_a[i] !== ma + 10'(i) || obs_d[i] !== fdata(fa + 16'(i))) begin
                    errors++;
                    $display("FAIL timeout_word[%0d]: addr=%h data=%h required %h %h",
                             i, obs_a[i], obs_d[i], ma + 10'(i), fdata(fa + 16'(i)));
                end
            end
        end
    endtask

    task automatic test_xfer(input string nm, input logic [15:0] fa, input logic [9:0] ma, input int n);
        int scyc;
        bit to;
        clear_mon();
        start_xfer(fa, ma, 16'(n), scyc);
        wait_enable(to);
        serve_n(n, 0);
        wait_end(100, to);
        checks++;
        if (to || n_done !== 1 || n_error !== 0 || obs_a.size() !== n) begin
            errors++;
            $display("FAIL %s_end: timeout=%0d dones=%0d errors=%0d writes=%0d required 0/1/0/%0d",
                     nm, to, n_done, n_error, obs_a.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (obs_a[i] !== ma + 10'(i) || obs_d[i] !== fdata(fa + 16'(i))) begin
                    errors++;
                    $display("FAIL %s_word[%0d]: addr=%h data=%h required %h %h",
                             nm, i, obs_a[i], obs_d[i], ma + 10'(i), fdata(fa + 16'(i)));
                end
            end
        end
        checks++;
        if (out_checksum !== exp_checksum(fa, n)) begin
            errors++;
            $display("FAIL %s_checksum: got %h required %h", nm, out_checksum, exp_checksum(fa, n));
        end
    endtask

    task automatic test_wrap();
        test_xfer("wrap", 16'($urandom), 10'h3FE, 3);
        checks++;
        if (obs_a.size() !== 3 || obs_a[2] !== 10'h000) begin
            errors++;
            $display("FAIL wrap_addr: writes=%0d last=%h required 3 writes ending at 000",
                     obs_a.size(), obs_a.size() > 2 ? obs_a[2] : 10'h3FF);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++)
            test_xfer("random", 16'($urandom), 10'($urandom), $urandom_range(1, 7));
    endtask

    task automatic test_release_busy();
        int scyc;
        bit to;
        bit busy_seen;
        logic w1, w2;
        logic [9:0] a1;
        logic [7:0] d1;
        clear_mon();
        start_xfer(16'($urandom), 10'($urandom), 16'd2, scyc);
        wait_enable(to);
        serve_n(2, 0);
        in_start = 1'b1;
        in_len   = 16'd5;
        send_word(8'($urandom), 1, w1, a1, d1, w2);
        in_start = 1'b0;
        checks++;
        if (w1 !== 1'b0 || w2 !== 1'b0) begin
            errors++;
            $display("FAIL release_word_ignored: wr=%b/%b required 0/0", w1, w2);
        end
        wait_end(100, to);
        busy_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            busy_seen = busy_seen | out_busy;
        end
        checks++;
        if (to || obs_a.size() !== 2 || n_done !== 1 || busy_seen !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_ignored: timeout=%0d writes=%0d dones=%0d busy_after=%b required 0/2/1/0",
                     to, obs_a.size(), n_done, busy_seen);
        end
    endtask

    task automatic test_reset_mid();
        int scyc;
        bit to;
        logic w1, w2;
        logic [9:0] a1;
        logic [7:0] d1;
        clear_mon();
        start_xfer(16'($urandom), 10'($urandom), 16'd6, scyc);
        wait_enable(to);
        serve_n(2, 0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_busy, out_flash_enable, out_mem_write} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_copy: busy=%b en=%b wr=%b required 000",
                     out_busy, out_flash_enable, out_mem_write);
        end
        @(negedge clk);
        rst = 1'b0;
        send_word(8'($urandom), 0, w1, a1, d1, w2);
        checks++;
        if (w1 !== 1'b0 || obs_a.size() !== 2 || n_done !== 0 || out_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_writes: wr=%b writes=%0d dones=%0d busy=%b required 0/2/0/0",
                     w1, obs_a.size(), n_done, out_busy);
        end
    endtask

    initial begin
        rst           = 1'b1;
        in_start      = 1'b0;
        in_flash_addr = '0;
        in_mem_addr   = '0;
        in_len        = '0;
        flash_data    = '0;
        wf            = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap();
        test_release_busy();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
